// File: rtl/cmp_pkg.sv
// +--------------------------------------------------------------------+
// | cmp_pkg : opcodes, widths and result decode for the compare unit    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

package cmp_pkg;

    localparam int CMP_W = 32;

    localparam logic [1:0] OP_SLT  = 2'b00;
    localparam logic [1:0] OP_SLTU = 2'b01;
    localparam logic [1:0] OP_BNE  = 2'b10;
    localparam logic [1:0] OP_BEQ  = 2'b11;

    // Select the single result bit from the subtractor flags.
    function automatic logic cmp_decode(
        input logic [1:0] op,
        input logic       lt_s,
        input logic       lt_u,
        input logic       eq
    );
        logic res;
        case (op)
            OP_SLT:  res = lt_s;
            OP_SLTU: res = lt_u;
            OP_BNE:  res = !eq;
            default: res = eq;
        endcase
        return res;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// +--------------------------------------------------------------------+
// | rr_arbiter : round-robin pick starting at ptr, one-hot + index out  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_valid
);

    logic [2*NREQ-1:0] w_rot;
    logic [IDW-1:0]    w_off;
    logic [IDW:0]      w_sum;

    // Rotating the doubled vector puts requester ptr at bit 0.
    assign w_rot = {req, req} >> ptr;

    always_comb begin
        gnt_valid = 1'b0;
        w_off     = '0;
        for (int j = NREQ - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                gnt_valid = 1'b1;
                w_off     = IDW'(j);
            end
        end
    end

    always_comb begin
        w_sum = {1'b0, ptr} + {1'b0, w_off};
        if (w_sum >= (IDW+1)'(NREQ)) begin
            w_sum = w_sum - (IDW+1)'(NREQ);
        end
    end

    assign gnt_idx = w_sum[IDW-1:0];

    always_comb begin
        gnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            gnt[i] = en && gnt_valid && (gnt_idx == IDW'(i));
        end
    end

endmodule

`default_nettype wire

// File: rtl/cmp_sched.sv
// +--------------------------------------------------------------------+
// | cmp_sched : round-robin shared 32-bit compare unit, valid/ready out |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module cmp_sched
    import cmp_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_result
);

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [CMP_W-1:0] rsp_result_q, rsp_result_d;

    logic             w_can_accept;
    logic             w_accept;
    logic [IDW-1:0]   w_gnt_idx;
    logic             w_gnt_valid;
    logic [1:0]       w_op;
    logic [CMP_W-1:0] w_a, w_b;
    logic [CMP_W:0]   w_sum;
    logic [CMP_W-1:0] w_diff;
    logic             w_ovf;
    logic             w_res;

    // A held result may be replaced in the same cycle it drains.
    assign w_can_accept = !rsp_valid_q || rsp_ready;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .en        (w_can_accept),
        .gnt       (req_ready),
        .gnt_idx   (w_gnt_idx),
        .gnt_valid (w_gnt_valid)
    );

    assign w_accept = w_gnt_valid && w_can_accept;

    // AND-OR operand mux keyed by the one-hot grant.
    always_comb begin
        w_op = '0;
        w_a  = '0;
        w_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_op = w_op | ({2{req_ready[i]}}     & req_op[2*i +: 2]);
            w_a  = w_a  | ({CMP_W{req_ready[i]}} & req_a[CMP_W*i +: CMP_W]);
            w_b  = w_b  | ({CMP_W{req_ready[i]}} & req_b[CMP_W*i +: CMP_W]);
        end
    end

    assign w_sum  = {1'b0, w_a} + {1'b0, ~w_b} + {{CMP_W{1'b0}}, 1'b1};
    assign w_diff = w_sum[CMP_W-1:0];
    assign w_ovf  = (w_a[CMP_W-1] != w_b[CMP_W-1]) && (w_diff[CMP_W-1] != w_a[CMP_W-1]);
    assign w_res  = cmp_decode(w_op,
                               w_diff[CMP_W-1] ^ w_ovf,
                               !w_sum[CMP_W],
                               w_diff == '0);

    always_comb begin
        ptr_d        = ptr_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        if (w_accept) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = w_gnt_idx;
            rsp_result_d = {{(CMP_W-1){1'b0}}, w_res};
            ptr_d        = (w_gnt_idx == IDW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;

endmodule

`default_nettype wire

// File: tb/tb_cmp_sched.sv
// +--------------------------------------------------------------------+
// | tb_cmp_sched : directed table-driven bench for cmp_sched            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_cmp_sched;
    import cmp_pkg::*;

    localparam int NREQ = 4;
    localparam int IDW  = 3;
    localparam int NVEC = 12;

    logic                clk;
    logic                reset_n;
    logic [NREQ-1:0]     req_valid;
    logic [2*NREQ-1:0]   req_op;
    logic [32*NREQ-1:0]  req_a;
    logic [32*NREQ-1:0]  req_b;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [31:0]         rsp_result;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int         id;
        logic [1:0] op;
        logic [31:0] a;
        logic [31:0] b;
        logic       exp;
    } vec_t;

    vec_t vecs [NVEC];

    cmp_sched #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        req_op[2*id +: 2] = op;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
    endtask

    task automatic chk_rsp(input string name, input int id, input logic [31:0] res);
        chk({name, ".valid"}, 32'(rsp_valid), 32'd1);
        chk({name, ".id"}, 32'(rsp_id), 32'(id));
        chk({name, ".result"}, rsp_result, res);
    endtask

    initial begin
        vecs[0]  = '{0, OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1};
        vecs[1]  = '{0, OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
        vecs[2]  = '{1, OP_SLT,  32'h8000_0000, 32'h0000_0001, 1'b1};
        vecs[3]  = '{2, OP_SLT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0};
        vecs[4]  = '{3, OP_BEQ,  32'd7,         32'd7,         1'b1};
        vecs[5]  = '{0, OP_BNE,  32'd7,         32'd8,         1'b1};
        vecs[6]  = '{1, OP_BNE,  32'd5,         32'd5,         1'b0};
        vecs[7]  = '{2, OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1};
        vecs[8]  = '{3, OP_SLT,  32'd5,         32'd5,         1'b0};
        vecs[9]  = '{0, OP_BEQ,  32'd7,         32'd8,         1'b0};
        vecs[10] = '{1, OP_SLTU, 32'd0,         32'd0,         1'b0};
        vecs[11] = '{2, OP_SLT,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1};

        reset_n   = 1'b0;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst.valid", 32'(rsp_valid), 32'd0);
        chk("rst.id", 32'(rsp_id), 32'd0);
        chk("rst.result", rsp_result, 32'd0);
        chk("rst.ready_idle", 32'(req_ready), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle.valid", 32'(rsp_valid), 32'd0);

        // Round-robin with all four requesters pending
        for (int i = 0; i < NREQ; i++) set_req(i, OP_BEQ, 32'(i), 32'(i));
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr.grant%0d", k), 32'(req_ready), 32'(1 << (k % NREQ)));
            @(posedge clk);
            @(negedge clk);
            chk_rsp($sformatf("rr.rsp%0d", k), k % NREQ, 32'd1);
        end
        req_valid = '0;   // ptr now 1

        // Stall with a held BNE 5,5 result from requester 1
        set_req(1, OP_BNE, 32'd5, 32'd5);
        req_valid = 4'b0010;
        @(posedge clk);   // accept id1, ptr -> 2
        @(negedge clk);
        rsp_ready = 1'b0;
        set_req(1, OP_BEQ, 32'd1, 32'd2);
        set_req(2, OP_SLT, 32'd1, 32'd2);
        req_valid = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stall.ready%0d", k), 32'(req_ready), 32'd0);
            chk_rsp($sformatf("stall.hold%0d", k), 1, 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("release.grant", 32'(req_ready), 32'b0100);
        @(posedge clk);
        @(negedge clk);
        chk_rsp("release.rsp", 2, 32'd1);

        // Wrap-around: ptr=3, only requester 2 pending
        set_req(2, OP_BEQ, 32'd9, 32'd9);
        req_valid = 4'b0100;
        #1;
        chk("wrap.grant", 32'(req_ready), 32'b0100);
        @(posedge clk);
        @(negedge clk);
        chk_rsp("wrap.rsp", 2, 32'd1);
        req_valid = '0;

        // Table vectors, one requester per cycle
        for (int v = 0; v < NVEC; v++) begin
            set_req(vecs[v].id, vecs[v].op, vecs[v].a, vecs[v].b);
            req_valid = NREQ'(1 << vecs[v].id);
            #1;
            chk($sformatf("vec%0d.grant", v), 32'(req_ready), 32'(1 << vecs[v].id));
            @(posedge clk);
            @(negedge clk);
            chk_rsp($sformatf("vec%0d", v), vecs[v].id, {31'd0, vecs[v].exp});
        end
        req_valid = '0;

        // Asynchronous reset while a result is held
        set_req(3, OP_BEQ, 32'd4, 32'd4);
        req_valid = 4'b1000;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("pre_rst.valid", 32'(rsp_valid), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_rst.valid", 32'(rsp_valid), 32'd0);
        chk("async_rst.id", 32'(rsp_id), 32'd0);
        chk("async_rst.result", rsp_result, 32'd0);
        chk("async_rst.ptr0", 32'(req_ready), 32'b0001);
        req_valid = '0;
        @(negedge clk);
        reset_n   = 1'b1;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst.no_rsp", 32'(rsp_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
